// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial adder datapath: feeder FSM states and
// the default operand width used by the adder, feeder and collector.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FLUSH = 2'b10
  } state_t;

endpackage

// File: rtl/serial_piso.sv
// Parallel-in serial-out register: loads a word, then shifts right with zero fill,
// presenting the LSB on sout.
import serial_add_pkg::*;

module serial_piso #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sh;

  // Load wins over shift so a new pair can be captured on the final flush edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
      sh <= {1'b0, sh[WIDTH-1:1]};
    end
  end

  assign sout = sh[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Streams two parallel operands LSB-first into the Moore serial adder, then one zero
// flush cycle for the carry. Define SERIAL_FEED_BACK2BACK_EN to accept during FLUSH.
import serial_add_pkg::*;

module serial_operand_feeder #(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  output logic             adder_clr,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic             shifting;
  logic             sa;
  logic             sb;

  assign accept   = in_valid & in_ready;
  assign shifting = (state == SHIFT);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  serial_piso #(.WIDTH(WIDTH)) u_piso_a (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shifting),
    .din   (op_a),
    .sout  (sa)
  );

  serial_piso #(.WIDTH(WIDTH)) u_piso_b (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (shifting),
    .din   (op_b),
    .sout  (sb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (shifting) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (in_valid) next_state = SHIFT;
      SHIFT: if (last_bit) next_state = FLUSH;
`ifdef SERIAL_FEED_BACK2BACK_EN
      FLUSH: next_state = in_valid ? SHIFT : IDLE;
`else
      FLUSH: next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // The adder is held cleared only while idle; a chained stream keeps it running.
  always_comb begin
    in_ready  = 1'b0;
    adder_clr = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        adder_clr = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        a    = sa;
        b    = sb;
      end
      FLUSH: begin
        busy = 1'b1;
        done = 1'b1;
`ifdef SERIAL_FEED_BACK2BACK_EN
        in_ready = 1'b1;
`endif
      end
      default: begin
        adder_clr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder driving a behavioural Moore serial adder; sums are
// compared against plain arithmetic on the captured operands.
module tb_serial_operand_feeder;

  localparam int W  = 4;
  localparam int W1 = W + 1;
`ifdef SERIAL_FEED_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         in_ready;
  logic         a;
  logic         b;
  logic         adder_clr;
  logic         busy;
  logic         done;

  logic carry = 1'b0;
  logic ysum = 1'b0;
  int   cyc = 0;
  logic yhist [0:4095];
  int   n_checks = 0;
  int   n_fail = 0;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .a         (a),
    .b         (b),
    .adder_clr (adder_clr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Downstream Moore serial adder: registered sum bit, cleared by adder_clr.
  always @(posedge clk) begin
    if (adder_clr) begin
      carry <= 1'b0;
      ysum  <= 1'b0;
    end else begin
      {carry, ysum} <= 2'(a) + 2'(b) + 2'(carry);
    end
  end

  // y as seen during each cycle, indexed by cycle number.
  always @(posedge clk) begin
    if (cyc < 4096) yhist[cyc[11:0]] <= ysum;
    cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, output int t0);
    @(negedge clk);
    op_a     = x;
    op_b     = y;
    in_valid = 1'b1;
    t0       = cyc;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  // Walks one stream from SHIFT cycle 'start' through FLUSH and the cycle after it.
  task automatic stream(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb,
                        input int start, input bit chain, input logic [W-1:0] nx,
                        input logic [W-1:0] ny, output int tn);
    logic [5:0] exp;
    tn = -1;
    for (int i = start; i < W; i++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b0, 1'b0, x[i], y[i]};
      n_checks++;
      if ({busy, in_ready, adder_clr, done, a, b} !== exp) begin
        n_fail++;
        $display("[TB] FAIL shift_bit%0d {busy,rdy,clr,done,a,b}: got %b required %b",
                 i, {busy, in_ready, adder_clr, done, a, b}, exp);
      end
      if (disturb && i < W - 1) begin
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    exp = {1'b1, B2B, 1'b0, 1'b1, 1'b0, 1'b0};
    n_checks++;
    if ({busy, in_ready, adder_clr, done, a, b} !== exp) begin
      n_fail++;
      $display("[TB] FAIL flush {busy,rdy,clr,done,a,b}: got %b required %b",
               {busy, in_ready, adder_clr, done, a, b}, exp);
    end
    if (chain) begin
      op_a     = nx;
      op_b     = ny;
      in_valid = 1'b1;
      if (B2B) tn = cyc;
    end
    @(negedge clk);
    if (chain && B2B) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, nx[0], ny[0]};
    end else begin
      exp = 6'b011000;
      if (chain) tn = cyc;
    end
    n_checks++;
    if ({busy, in_ready, adder_clr, done, a, b} !== exp) begin
      n_fail++;
      $display("[TB] FAIL after_flush {busy,rdy,clr,done,a,b}: got %b required %b",
               {busy, in_ready, adder_clr, done, a, b}, exp);
    end
    if (chain && B2B) in_valid = 1'b0;
  endtask

  task automatic check_sum(input int t0, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    logic [W:0] e;
    int         idx;
    e = W1'(x) + W1'(y);
    r = '0;
    for (int k = 0; k < 4 * W + 8 && cyc <= t0 + 2 + W; k++) @(posedge clk);
    #1;
    n_checks++;
    if (cyc <= t0 + 2 + W) begin
      n_fail++;
      $display("[TB] FAIL sum_timeout: cycle %0d required beyond %0d", cyc, t0 + 2 + W);
    end else begin
      for (int k = 0; k <= W; k++) begin
        idx  = t0 + 2 + k;
        r[k] = yhist[idx[11:0]];
      end
      if (r !== e) begin
        n_fail++;
        $display("[TB] FAIL sum %0h+%0h: got %0h required %0h", x, y, r, e);
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, in_ready, adder_clr, done, a, b} !== 6'b011000) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b required 011000",
               {busy, in_ready, adder_clr, done, a, b});
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, adder_clr, done, a, b} !== 6'b011000) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b required 011000",
               {busy, in_ready, adder_clr, done, a, b});
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] xs [8];
    logic [W-1:0] ys [8];
    int t0;
    int tn;
    xs[0] = 4'hB; ys[0] = 4'h3;
    xs[1] = 4'hF; ys[1] = 4'h1;
    xs[2] = 4'h0; ys[2] = 4'h0;
    xs[3] = 4'hF; ys[3] = 4'hF;
    for (int i = 4; i < 8; i++) begin
      xs[i] = W'($urandom);
      ys[i] = W'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      accept(xs[i], ys[i], t0);
      stream(xs[i], ys[i], 1'b0, 0, 1'b0, '0, '0, tn);
      check_sum(t0, xs[i], ys[i]);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x;
    logic [W-1:0] y;
    int t0;
    int tn;
    for (int i = 0; i < 3; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      accept(x, y, t0);
      stream(x, y, 1'b1, 0, 1'b0, '0, '0, tn);
      check_sum(t0, x, y);
    end
  endtask

  task automatic test_midstream_reset();
    int t0;
    int tn;
    accept(4'hC, 4'h6, t0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, in_ready, adder_clr, done, a, b} !== 6'b011000) begin
      n_fail++;
      $display("[TB] FAIL midstream_reset: got %b required 011000",
               {busy, in_ready, adder_clr, done, a, b});
    end
    @(negedge clk);
    reset = 1'b1;
    accept(4'h5, 4'h2, t0);
    stream(4'h5, 4'h2, 1'b0, 0, 1'b0, '0, '0, tn);
    check_sum(t0, 4'h5, 4'h2);
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int tn;
    int gap;
    accept(4'h3, 4'h3, t1);
    stream(4'h3, 4'h3, 1'b0, 0, 1'b1, 4'h9, 4'h8, t2);
    stream(4'h9, 4'h8, 1'b0, B2B ? 1 : 0, 1'b0, '0, '0, tn);
    gap = B2B ? W + 1 : W + 2;
    n_checks++;
    if (t2 - t1 !== gap) begin
      n_fail++;
      $display("[TB] FAIL b2b_gap: got %0d cycles required %0d", t2 - t1, gap);
    end
    check_sum(t1, 4'h3, 4'h3);
    check_sum(t2, 4'h9, 4'h8);
  endtask

  initial begin
    $display("[TB] serial_operand_feeder bench, WIDTH=%0d, back-to-back=%0d", W, B2B);
    test_reset();
    test_basic();
    test_backpressure();
    test_midstream_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
